// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory bus arbiter.
// Requests, read tags and id-width helper live here.
package mem_arb_pkg;

    localparam int MAX_ID_W = 3;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } mem_req_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered pointer.
// Search starts one past the last winner and wraps.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N    = 2,
    parameter int ID_W = id_w(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W-1:0] last_gnt;
    logic            found;
    int              idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_gnt) + k) % N;
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_id      = ID_W'(idx);
            end
        end
        if (reset) begin
            gnt    = '0;
            gnt_id = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= ID_W'(N - 1);
        end else if (advance) begin
            last_gnt <= gnt_id;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous memory bus among N_REQ requesters and
// routes read data back to its owner after RD_LATENCY cycles.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*32-1:0]   req_addr,
    input  logic [N_REQ*32-1:0]   req_wdata,
    input  logic [N_REQ*4-1:0]    req_be,
    input  logic [N_REQ-1:0]      req_we,
    output logic [N_REQ-1:0]      req_gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_data,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_data_i,
    output logic [3:0]            mem_data_en,
    output logic                  mem_write_en,
    input  logic [31:0]           mem_data_o
);

    localparam int ID_W = id_w(N_REQ);

    logic [ID_W-1:0] gnt_id;
    logic            granted;
    logic            rd_issue;
    mem_req_t        win;
    rd_tag_t         pipe [RD_LATENCY];
    rd_tag_t         last;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (granted),
        .gnt     (req_gnt),
        .gnt_id  (gnt_id)
    );

    assign granted = |req_gnt;

    always_comb begin
        win = '0;
        if (granted) begin
            win.addr  = req_addr[int'(gnt_id)*32 +: 32];
            win.wdata = req_wdata[int'(gnt_id)*32 +: 32];
            win.be    = req_be[int'(gnt_id)*4 +: 4];
            win.we    = req_we[gnt_id];
        end
    end

    assign mem_addr     = win.addr;
    assign mem_data_i   = win.wdata;
    assign mem_data_en  = win.be;
    assign mem_write_en = win.we;

    assign rd_issue = granted & ~win.we;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= rd_issue;
            pipe[0].id    <= rd_issue ? MAX_ID_W'(gnt_id) : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign last = pipe[RD_LATENCY-1];

    // A tag still in the last stage while reset is high belongs to
    // a discarded read, so responses are masked during reset too.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (last.valid && !reset) begin
            rsp_valid[int'(last.id)] = 1'b1;
            rsp_data                 = mem_data_o;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: two arbiters (read latency 1 and 3) on shared
// request inputs, each backed by its own synchronous memory model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_be = '0;
    logic [1:0]  req_we = '0;

    logic [1:0]  g1, v1, g3, v3;
    logic [31:0] d1, a1, wd1, md1, d3, a3, wd3, md3;
    logic [3:0]  be1, be3;
    logic        we1, we3;

    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] r1;
    logic [31:0] r3 [3];

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.N_REQ(2), .RD_LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_we(req_we), .req_gnt(g1), .rsp_valid(v1), .rsp_data(d1),
        .mem_addr(a1), .mem_data_i(wd1), .mem_data_en(be1),
        .mem_write_en(we1), .mem_data_o(md1)
    );

    mem_bus_arbiter #(.N_REQ(2), .RD_LATENCY(3)) u3 (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_we(req_we), .req_gnt(g3), .rsp_valid(v3), .rsp_data(d3),
        .mem_addr(a3), .mem_data_i(wd3), .mem_data_en(be3),
        .mem_write_en(we3), .mem_data_o(md3)
    );

    always @(posedge clk) begin
        if (we1)
            for (int b = 0; b < 4; b++)
                if (be1[b]) mem1[a1[9:2]][b*8 +: 8] <= wd1[b*8 +: 8];
        r1 <= mem1[a1[9:2]];
    end
    assign md1 = r1;

    always @(posedge clk) begin
        if (we3)
            for (int b = 0; b < 4; b++)
                if (be3[b]) mem3[a3[9:2]][b*8 +: 8] <= wd3[b*8 +: 8];
        r3[0] <= mem3[a3[9:2]];
        r3[1] <= r3[0];
        r3[2] <= r3[1];
    end
    assign md3 = r3[2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_addr[i*32 +: 32]  = addr;
        req_wdata[i*32 +: 32] = wd;
        req_be[i*4 +: 4]      = be;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = '0;
            mem3[i] = '0;
        end
        mem1[4]  = 32'hDEADBEEF; mem3[4]  = 32'hDEADBEEF;
        mem1[8]  = 32'hAABBCCDD; mem3[8]  = 32'hAABBCCDD;
        mem1[12] = 32'h30303030; mem3[12] = 32'h30303030;
        mem1[16] = 32'h40404040; mem3[16] = 32'h40404040;

        // reset with both requesting
        set_req(0, 1, 0, 32'h10, 0, 4'hF);
        set_req(1, 1, 0, 32'h20, 0, 4'hF);
        nxt(); smp();
        chk("rst_gnt", 32'(g1), 0);
        chk("rst_we", 32'(we1), 0);
        chk("rst_de", 32'(be1), 0);
        chk("rst_rsp", 32'(v1), 0);
        nxt();
        reset = 1'b0;
        req_valid = 2'b01;

        // single read
        smp();
        chk("rd_gnt", 32'(g1), 1);
        chk("rd_addr", a1, 32'h10);
        chk("rd_we", 32'(we1), 0);
        nxt();
        req_valid = 2'b00;
        smp();
        chk("rd_rsp", 32'(v1), 1);
        chk("rd_data", d1, 32'hDEADBEEF);
        chk("rd_idle_gnt", 32'(g1), 0);

        // reset, then contention
        nxt();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        set_req(0, 1, 0, 32'h30, 0, 4'hF);
        set_req(1, 1, 0, 32'h40, 0, 4'hF);
        smp();
        chk("ct0_gnt", 32'(g1), 1);
        chk("ct0_addr", a1, 32'h30);
        nxt(); smp();
        chk("ct1_gnt", 32'(g1), 2);
        chk("ct1_addr", a1, 32'h40);
        chk("ct1_rsp", 32'(v1), 1);
        chk("ct1_data", d1, 32'h30303030);
        nxt(); smp();
        chk("ct2_gnt", 32'(g1), 1);
        chk("ct2_rsp", 32'(v1), 2);
        chk("ct2_data", d1, 32'h40404040);
        nxt(); smp();
        chk("ct3_gnt", 32'(g1), 2);
        chk("ct3_rsp", 32'(v1), 1);
        chk("ct3_data", d1, 32'h30303030);
        nxt();
        req_valid = 2'b00;
        smp();
        chk("ct4_rsp", 32'(v1), 2);
        chk("ct4_data", d1, 32'h40404040);

        // requester 1: partial write then read back
        nxt();
        set_req(1, 1, 1, 32'h20, 32'h11223344, 4'b0011);
        smp();
        chk("wr_gnt", 32'(g1), 2);
        chk("wr_we", 32'(we1), 1);
        chk("wr_de", 32'(be1), 32'h3);
        chk("wr_wd", wd1, 32'h11223344);
        chk("wr_addr", a1, 32'h20);
        nxt();
        req_we = 2'b00;
        smp();
        chk("wr_no_rsp", 32'(v1), 0);
        chk("rb_gnt", 32'(g1), 2);
        chk("rb_we", 32'(we1), 0);
        nxt();
        req_valid = 2'b00;
        smp();
        chk("rb_rsp", 32'(v1), 2);
        chk("rb_data", d1, 32'hAABB3344);

        // idle cycle, pointer must hold at 1
        nxt(); smp();
        chk("idle_gnt", 32'(g1), 0);
        chk("idle_we", 32'(we1), 0);
        chk("idle_de", 32'(be1), 0);
        chk("idle_rsp", 32'(v1), 0);
        nxt();
        req_valid = 2'b11;
        smp();
        chk("hold_gnt0", 32'(g1), 1);
        nxt(); smp();
        chk("hold_gnt1", 32'(g1), 2);

        // latency 3: reads from 0,1,0 back to back
        nxt();
        req_valid = 2'b00;
        nxt(); nxt(); nxt();
        set_req(0, 1, 0, 32'h10, 0, 4'hF);
        smp();
        chk("l3_g0", 32'(g3), 1);
        nxt();
        req_valid = 2'b00;
        set_req(1, 1, 0, 32'h30, 0, 4'hF);
        smp();
        chk("l3_g1", 32'(g3), 2);
        chk("l3_rsp1", 32'(v3), 0);
        nxt();
        req_valid = 2'b00;
        set_req(0, 1, 0, 32'h40, 0, 4'hF);
        smp();
        chk("l3_g2", 32'(g3), 1);
        chk("l3_rsp2", 32'(v3), 0);
        nxt();
        req_valid = 2'b00;
        smp();
        chk("l3_rsp3", 32'(v3), 1);
        chk("l3_data3", d3, 32'hDEADBEEF);
        nxt(); smp();
        chk("l3_rsp4", 32'(v3), 2);
        chk("l3_data4", d3, 32'h30303030);
        nxt(); smp();
        chk("l3_rsp5", 32'(v3), 1);
        chk("l3_data5", d3, 32'h40404040);
        nxt(); smp();
        chk("l3_rsp6", 32'(v3), 0);

        // reset right after a read grant
        nxt();
        set_req(0, 1, 0, 32'h10, 0, 4'hF);
        smp();
        chk("mr_gnt", 32'(g1), 1);
        nxt();
        reset = 1'b1;
        req_valid = 2'b11;
        smp();
        chk("mr_rst_gnt", 32'(g1), 0);
        chk("mr_rst_we", 32'(we1), 0);
        chk("mr_rst_rsp1", 32'(v1), 0);
        chk("mr_rst_rsp3", 32'(v3), 0);
        nxt();
        reset = 1'b0;
        smp();
        chk("mr_first", 32'(g1), 1);
        chk("mr_rsp1", 32'(v1), 0);
        chk("mr_rsp3a", 32'(v3), 0);
        nxt(); smp();
        chk("mr_second", 32'(g1), 2);
        chk("mr_rsp3b", 32'(v3), 0);
        nxt();
        req_valid = 2'b00;
        smp();
        chk("mr_rsp3c", 32'(v3), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
